// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  // Default operand width in bits (legal range 2..32)
  localparam int unsigned WIDTH_DEFAULT = 8;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder: two half-adder stages whose carries are ORed together.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: operand bits
  assign ha0_s = x ^ y;
  assign ha0_c = x & y;

  // Second half adder: partial sum plus carry-in
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  // A carry comes out of at most one of the two stages
  assign cout  = ha0_c | ha1_c;

endmodule : full_adder_bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: loads two operands, adds them LSB-first over
// WIDTH cycles through a single full adder, then pulses done with the result.
// Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' input that turns
// the operation into a - b (carry_out = 1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps this at least 1 bit
  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   psum;
  logic               carry;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   b_load;
  logic               carry_init;
  logic               fa_s;
  logic               fa_cout;
  logic               last_bit;

  // Operand B / initial carry selection at load time
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  // Final RUN cycle is the one processing bit WIDTH-1
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // The only arithmetic in the datapath
  full_adder_bit u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Controller FSM with shift datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      psum      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            psum  <= '0;
            carry <= carry_init;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= {fa_s, psum[WIDTH-1:1]};
          carry <= fa_cout;
          count <= count + CNT_W'(1);
          if (last_bit) begin
            // Result includes the bit being produced on this edge
            sum       <= {fa_s, psum[WIDTH-1:1]};
            carry_out <= fa_cout;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // start is ignored here; one-cycle completion pulse
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). Honors SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  int vec_cnt;
  int mis_cnt;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t tbl[$];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {carry_out, sum}
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic s);
    int r;
    if (s) begin
      r = int'(x) - int'(y);
      return {(x >= y), 8'(r & 255)};
    end
    r = int'(x) + int'(y);
    return {(r >= 256), 8'(r % 256)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full operation: start, latency, busy width, result, done width
  task automatic do_op(input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic sub_i, input string nm);
    int         lat;
    int         bcnt;
    logic [8:0] exp;
    exp = model(a_i, b_i, sub_i);
    @(negedge clk);
    a     = a_i;
    b     = b_i;
`ifdef SERIAL_ADD_SUB_EN
    sub   = sub_i;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd8);
    chk({nm, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({nm, "_sum"}, 32'(sum), 32'(exp[7:0]));
    chk({nm, "_cout"}, 32'(carry_out), 32'(exp[8]));
    @(posedge clk); #1;
    chk({nm, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int         t;
    int         dts[$];
    logic       seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;

    vec_cnt = 0;
    mis_cnt = 0;
    rst     = 1'b1;
    start   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
`ifdef SERIAL_ADD_SUB_EN
    sub     = 1'b0;
`endif

    // Reset state, with start asserted to show reset priority
    @(negedge clk);
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Directed table
    tbl.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    tbl.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0});
    tbl.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 8'h00, 1'b1});
`endif
    foreach (tbl[i]) begin
      // Table expectations are independent of the model; cross-check both
      chk($sformatf("tbl%0d_model", i), 32'(model(tbl[i].a, tbl[i].b, tbl[i].sub)),
          32'({tbl[i].exp_cout, tbl[i].exp_sum}));
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, $sformatf("tbl%0d", i));
    end

    // start held high: operations accepted every 10 cycles
    @(negedge clk);
    a     = 8'hA5;
    b     = 8'h5A;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    start = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (done) begin
        dts.push_back(t);
        chk("hold_sum", 32'(sum), 32'hFF);
        chk("hold_cout", 32'(carry_out), 32'd0);
      end
    end
    start = 1'b0;
    chk("hold_done_count", 32'(dts.size()), 32'd2);
    if (dts.size() >= 2) begin
      chk("hold_done0_edge", 32'(dts[0]), 32'd8);
      chk("hold_done1_edge", 32'(dts[1]), 32'd18);
    end
    @(posedge clk); #1;
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // Start during RUN is ignored
    @(negedge clk);
    a     = 8'h3C;
    b     = 8'h0F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t     = 0;
    while (!done && t < 20) begin
      if (t == 3) begin
        a     = 8'h11;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk("ign_latency", 32'(t), 32'd8);
    chk("ign_sum", 32'(sum), 32'h4B);
    chk("ign_cout", 32'(carry_out), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("ign_no_second_op", 32'(seen), 32'd0);
    chk("ign_sum_held", 32'(sum), 32'h4B);

    // Reset mid-RUN discards the operation
    @(negedge clk);
    a     = 8'h80;
    b     = 8'h80;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(carry_out), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    do_op(8'h80, 8'h80, 1'b0, "after_rst");

    // Randomized operations against the model
    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; the reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin one addition.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have port sum, output, WIDTH bits, the registered result.
REQ-010 The block SHALL have port carry_out, output, 1 bit, the registered final carry.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-012 In IDLE with start=1, the next edge SHALL:
- load a and b into shift registers;
- clear the internal carry and the bit counter;
- enter RUN.
REQ-013 Each RUN cycle SHALL:
- add the shift-register LSBs and the carry in a 1-bit full adder;
- shift the sum bit into the MSB of a partial-sum register;
- shift the operands right;
- update the carry;
- increment the counter.
REQ-014 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE and, on that same edge, load sum from the partial sum and carry_out from the carry.
REQ-015 done SHALL be high only in DONE; DONE SHALL return to IDLE on the next edge, so done is exactly 1 cycle wide and first appears WIDTH edges after the accepting edge.
REQ-016 busy SHALL be high only in RUN.
REQ-017 start SHALL be ignored in RUN and DONE; no queuing.
REQ-018 sum and carry_out SHALL hold their last result until the next completion.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH; carry_out SHALL equal bit WIDTH of a+b.
REQ-020 Back-to-back operations SHALL be accepted with start asserted in the cycle after done (IDLE), giving a throughput of WIDTH+2 cycles per operation.

Reset
REQ-021 On rst=1 at an edge, the block SHALL enter IDLE and clear busy, done, sum, carry_out, the counter, the carry and the shift registers to 0, including mid-RUN; the partial result SHALL be discarded.
REQ-022 rst SHALL take priority over start in the same cycle.

Configuration
REQ-023 With macro SERIAL_ADD_SUB_EN defined, the block SHALL:
- add input port sub, 1 bit, sampled with start;
- when sub=1, load the bitwise inverse of b and initialise the carry to 1, computing a-b;
- set carry_out=1 when there is no borrow.
REQ-024 Without SERIAL_ADD_SUB_EN, the block SHALL have no sub port and SHALL behave as an adder only.

Structure
REQ-025 A shared package serial_add_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-026 The 1-bit adder SHALL be a sub-module full_adder_bit (inputs x, y, cin; outputs s, cout) built from two half-adder stages plus an OR gate; the controller SHALL contain no other arithmetic.

Verification
REQ-027 The bench SHALL cover the following directed scenarios, all with WIDTH=8:
- a=0x00, b=0x00, one start pulse -> done after 8 edges; sum=0x00, carry_out=0; busy high for 8 cycles.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1; done is exactly 1 cycle wide.
- a=0xA5, b=0x5A, then start held high continuously -> sum=0xFF, carry_out=0; a second operation accepted only after the DONE state, i.e. starts spaced 10 cycles apart.
- a=0x3C, b=0x0F, start; at RUN cycle 4, a second start with a=0x11 -> ignored; sum=0x4B, carry_out=0.
- a=0x80, b=0x80, start; rst at RUN cycle 5 -> IDLE next edge, all outputs 0, no done pulse; a new start then yields sum=0x00, carry_out=1.
- With SERIAL_ADD_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0; a=0x07, b=0x05, sub=1 -> sum=0x02, carry_out=1.
